rv_iopmp_check_arbiter: RTL and testbench

//  Shares the single rv_iopmp_matching_logic check port between NUM_REQ requesters
//  (e.g. the AW-path and AR-path checkers of the AXI data abstractor).

---
 rtl/rv_iopmp_pkg.sv | 30 +++
 rtl/rv_iopmp_rr_pick.sv | 34 +++
 rtl/rv_iopmp_check_arbiter.sv | 112 +++++++++++
 tb/tb_rv_iopmp_check_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: check request fields, access kinds and arbiter FSM states.
// Pure type/constant package, no logic and no handshake.
package rv_iopmp_pkg;

  localparam int unsigned ADDR_WIDTH = 64;
  localparam int unsigned SID_WIDTH  = 1;
  localparam int unsigned NB_WIDTH   = 4;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2,
    ACC_EXEC  = 2'd3
  } access_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] total_length;
    logic [NB_WIDTH-1:0]   num_bytes;
    logic [SID_WIDTH-1:0]  sid;
    access_t               access_type;
  } check_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rv_iopmp_rr_pick.sv
// Combinational round-robin picker: first valid bit at or after i_ptr, wrapping; zero latency.
// No backpressure of its own; o_any is low when nothing is valid.
module rv_iopmp_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_vld,
  input  logic [IDXW-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt_oh,
  output logic [IDXW-1:0]    o_gnt_idx,
  output logic               o_any
);

  int unsigned w_idx;

  // Scan from the farthest offset down so the closest valid to i_ptr overwrites the rest.
  always_comb begin
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_idx     = 0;
    for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
      w_idx = int'(i_ptr) + off;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (i_vld[IDXW'(w_idx)]) begin
        o_gnt_oh                 = '0;
        o_gnt_oh[IDXW'(w_idx)]   = 1'b1;
        o_gnt_idx                = IDXW'(w_idx);
        o_any                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv_iopmp_check_arbiter.sv
// Round-robin share of the matching-logic check port; ready same cycle, ml_en_o next cycle, result 1 cycle after ml_valid_i.
// One check in flight: ready only in IDLE, ISSUE holds while ml_ready_i is low, watchdog forces a deny.
module rv_iopmp_check_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  check_req_t [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic                    rsp_allow_o,
  output logic                    ml_en_o,
  output check_req_t              ml_req_o,
  input  logic                    ml_ready_i,
  input  logic                    ml_valid_i,
  input  logic                    ml_allow_i,
  output logic                    timeout_o
);

  localparam int unsigned IDXW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [IDXW-1:0]     r_rr_ptr;
  logic [IDXW-1:0]     r_gnt_idx;
  logic [NUM_REQ-1:0]  r_gnt_oh;
  check_req_t          r_buf;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_REQ-1:0]  r_rsp_vld;
  logic                r_rsp_allow;
  logic                r_timeout;

  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [IDXW-1:0]     w_pick_idx;
  logic                w_any;
  logic                w_grant;
  logic                w_valid_hit;
  logic                w_tmo_hit;
  logic                w_done;
  logic [IDXW-1:0]     w_ptr_nxt;

  rv_iopmp_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_pick (
    .i_vld     (req_valid_i),
    .i_ptr     (r_rr_ptr),
    .o_gnt_oh  (w_pick_oh),
    .o_gnt_idx (w_pick_idx),
    .o_any     (w_any)
  );

  assign w_grant     = (r_state == IDLE) && w_any;
  assign w_valid_hit = (r_state == WAIT) && ml_valid_i;
  // A result landing on the watchdog's last cycle beats the forced deny.
  assign w_tmo_hit   = (TIMEOUT != 0) && (r_state != IDLE) && (r_cnt == CNT_LAST) && !w_valid_hit;
  assign w_done      = w_valid_hit || w_tmo_hit;
  assign w_ptr_nxt   = (r_gnt_idx == IDXW'(NUM_REQ - 1)) ? '0 : r_gnt_idx + IDXW'(1);

  assign req_ready_o = (r_state == IDLE) ? w_pick_oh : '0;
  assign ml_en_o     = (r_state == ISSUE);
  assign ml_req_o    = (r_state != IDLE) ? r_buf : '0;
  assign rsp_valid_o = r_rsp_vld;
  assign rsp_allow_o = r_rsp_allow;
  assign timeout_o   = r_timeout;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = ISSUE;
      ISSUE:   if (w_tmo_hit) w_state_nxt = IDLE;
               else if (ml_ready_i) w_state_nxt = WAIT;
      WAIT:    if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_gnt_idx   <= '0;
      r_gnt_oh    <= '0;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_rsp_vld   <= '0;
      r_rsp_allow <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_vld   <= w_done ? r_gnt_oh : '0;
      r_rsp_allow <= w_valid_hit & ml_allow_i;
      r_timeout   <= w_tmo_hit;
      if (w_grant) begin
        r_buf     <= req_i[w_pick_idx];
        r_gnt_idx <= w_pick_idx;
        r_gnt_oh  <= w_pick_oh;
        r_cnt     <= '0;
      end else if (r_state != IDLE) begin
        r_cnt     <= r_cnt + CNT_W'(1);
      end
      if (w_done) r_rr_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rv_iopmp_check_arbiter.sv
// Directed bench for rv_iopmp_check_arbiter (NUM_REQ=2, TIMEOUT=16).
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
module tb_rv_iopmp_check_arbiter;
  import rv_iopmp_pkg::*;

  logic             clk;
  logic             rst_ni;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  check_req_t [1:0] req;
  logic [1:0]       rsp_valid;
  logic             rsp_allow;
  logic             ml_en;
  check_req_t       ml_req;
  logic             ml_ready;
  logic             ml_valid;
  logic             ml_allow;
  logic             timeout;

  int n_checks = 0;
  int n_fail   = 0;

  rv_iopmp_check_arbiter #(
    .NUM_REQ (2),
    .TIMEOUT (16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_i       (req),
    .rsp_valid_o (rsp_valid),
    .rsp_allow_o (rsp_allow),
    .ml_en_o     (ml_en),
    .ml_req_o    (ml_req),
    .ml_ready_i  (ml_ready),
    .ml_valid_i  (ml_valid),
    .ml_allow_i  (ml_allow),
    .timeout_o   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic check_req_t mk(input logic [63:0] a, input logic [63:0] len,
                                    input logic [3:0] nb, input logic s, input access_t at);
    check_req_t r;
    r.addr         = a;
    r.total_length = len;
    r.num_bytes    = nb;
    r.sid          = s;
    r.access_type  = at;
    return r;
  endfunction

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b exp 00", req_ready); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b exp 00", rsp_valid); end
    n_checks++; if (ml_en !== 1'b0) begin n_fail++; $display("FAIL rst_ml_en: got %b exp 0", ml_en); end
    n_checks++; if (ml_req !== '0) begin n_fail++; $display("FAIL rst_ml_req: got %h exp 0", ml_req); end
    n_checks++; if ({rsp_allow, timeout} !== 2'b00) begin n_fail++; $display("FAIL rst_allow_tmo: got %b exp 00", {rsp_allow, timeout}); end
    @(negedge clk); rst_ni = 1'b1; #1;
    @(negedge clk); #1;
    n_checks++; if ({req_ready, rsp_valid, ml_en, timeout} !== 6'b0) begin n_fail++; $display("FAIL rst_after_release: got %b exp 000000", {req_ready, rsp_valid, ml_en, timeout}); end
  endtask

  task automatic test_single();
    check_req_t exp_req;
    exp_req = mk(64'h8000_0000, 64'h40, 4'd8, 1'b0, ACC_READ);
    @(negedge clk); req[0] = exp_req; req_valid = 2'b01; ml_ready = 1'b1; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready_t0: got %b exp 01", req_ready); end
    n_checks++; if (ml_en !== 1'b0) begin n_fail++; $display("FAIL single_en_t0: got %b exp 0", ml_en); end
    @(negedge clk); req_valid = 2'b00; #1;
    n_checks++; if (ml_en !== 1'b1) begin n_fail++; $display("FAIL single_en_t1: got %b exp 1", ml_en); end
    n_checks++; if (ml_req !== exp_req) begin n_fail++; $display("FAIL single_ml_req_t1: got %h exp %h", ml_req, exp_req); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL single_ready_t1: got %b exp 00", req_ready); end
    @(negedge clk); ml_valid = 1'b1; ml_allow = 1'b1; #1;
    n_checks++; if (ml_en !== 1'b0) begin n_fail++; $display("FAIL single_en_t2: got %b exp 0", ml_en); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_rsp_early: got %b exp 00", rsp_valid); end
    n_checks++; if (ml_req !== exp_req) begin n_fail++; $display("FAIL single_ml_req_t2: got %h exp %h", ml_req, exp_req); end
    @(negedge clk); ml_valid = 1'b0; ml_allow = 1'b0; #1;
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp_t3: got %b exp 01", rsp_valid); end
    n_checks++; if (rsp_allow !== 1'b1) begin n_fail++; $display("FAIL single_allow_t3: got %b exp 1", rsp_allow); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL single_tmo_t3: got %b exp 0", timeout); end
    @(negedge clk); #1;
    n_checks++; if ({rsp_valid, rsp_allow} !== 3'b000) begin n_fail++; $display("FAIL single_rsp_pulse: got %b exp 000", {rsp_valid, rsp_allow}); end
  endtask

  // Also covers back-to-back: each response cycle is the next grant cycle.
  task automatic test_contention();
    int g;
    logic [1:0] exp_oh;
    logic [1:0] nxt_oh;
    @(negedge clk); rst_ni = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    @(negedge clk);
    req[0] = mk(64'h1000, 64'h10, 4'd4, 1'b0, ACC_WRITE);
    req[1] = mk(64'h2000, 64'h20, 4'd8, 1'b1, ACC_READ);
    req_valid = 2'b11; ml_ready = 1'b1; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL cont_ready_first: got %b exp 01", req_ready); end
    for (int k = 0; k < 4; k++) begin
      g      = k % 2;
      exp_oh = (g == 0) ? 2'b01 : 2'b10;
      nxt_oh = (g == 0) ? 2'b10 : 2'b01;
      @(negedge clk); #1;
      n_checks++; if (ml_en !== 1'b1) begin n_fail++; $display("FAIL cont_en_%0d: got %b exp 1", k, ml_en); end
      n_checks++; if (ml_req !== req[g]) begin n_fail++; $display("FAIL cont_ml_req_%0d: got %h exp %h", k, ml_req, req[g]); end
      @(negedge clk); ml_valid = 1'b1; ml_allow = (g == 0); #1;
      @(negedge clk); ml_valid = 1'b0; ml_allow = 1'b0;
      if (k == 3) req_valid = 2'b00;
      #1;
      n_checks++; if (rsp_valid !== exp_oh) begin n_fail++; $display("FAIL cont_rsp_%0d: got %b exp %b", k, rsp_valid, exp_oh); end
      n_checks++; if (rsp_allow !== (g == 0)) begin n_fail++; $display("FAIL cont_allow_%0d: got %b exp %b", k, rsp_allow, (g == 0)); end
      if (k < 3) begin
        n_checks++; if (req_ready !== nxt_oh) begin n_fail++; $display("FAIL cont_b2b_ready_%0d: got %b exp %b", k, req_ready, nxt_oh); end
      end
    end
  endtask

  task automatic test_stall();
    check_req_t exp_req;
    exp_req = mk(64'h3000, 64'h80, 4'd2, 1'b1, ACC_EXEC);
    @(negedge clk); req[0] = exp_req; req_valid = 2'b01; ml_ready = 1'b0; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL stall_ready: got %b exp 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    req[0] = mk(64'hDEAD_0000, 64'h1, 4'd1, 1'b0, ACC_WRITE);
    #1;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) begin @(negedge clk); #1; end
      n_checks++; if (ml_en !== 1'b1) begin n_fail++; $display("FAIL stall_en_c%0d: got %b exp 1", c, ml_en); end
      n_checks++; if (ml_req !== exp_req) begin n_fail++; $display("FAIL stall_req_c%0d: got %h exp %h", c, ml_req, exp_req); end
    end
    @(negedge clk); ml_ready = 1'b1; #1;
    n_checks++; if (ml_en !== 1'b1) begin n_fail++; $display("FAIL stall_en_accept: got %b exp 1", ml_en); end
    @(negedge clk); ml_valid = 1'b1; ml_allow = 1'b0; #1;
    n_checks++; if (ml_en !== 1'b0) begin n_fail++; $display("FAIL stall_en_wait: got %b exp 0", ml_en); end
    n_checks++; if (ml_req !== exp_req) begin n_fail++; $display("FAIL stall_req_wait: got %h exp %h", ml_req, exp_req); end
    @(negedge clk); ml_valid = 1'b0; #1;
    n_checks++; if ({rsp_valid, rsp_allow, timeout} !== 4'b0100) begin n_fail++; $display("FAIL stall_rsp: got %b exp 0100", {rsp_valid, rsp_allow, timeout}); end
  endtask

  task automatic test_timeout();
    @(negedge clk); req[1] = mk(64'h4000, 64'h8, 4'd8, 1'b1, ACC_READ); req_valid = 2'b10; ml_ready = 1'b1; #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL tmo_ready: got %b exp 10", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    n_checks++; if (ml_en !== 1'b1) begin n_fail++; $display("FAIL tmo_en: got %b exp 1", ml_en); end
    for (int c = 2; c <= 16; c++) begin
      @(negedge clk); #1;
      n_checks++; if ({rsp_valid, timeout} !== 3'b000) begin n_fail++; $display("FAIL tmo_early_c%0d: got %b exp 000", c, {rsp_valid, timeout}); end
    end
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL tmo_rsp: got %b exp 10", rsp_valid); end
    n_checks++; if (rsp_allow !== 1'b0) begin n_fail++; $display("FAIL tmo_allow: got %b exp 0", rsp_allow); end
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: got %b exp 1", timeout); end
    n_checks++; if ({ml_en, ml_req} !== '0) begin n_fail++; $display("FAIL tmo_idle: got en=%b req=%h exp 0", ml_en, ml_req); end
    @(negedge clk); #1;
    n_checks++; if ({rsp_valid, timeout} !== 3'b000) begin n_fail++; $display("FAIL tmo_pulse_end: got %b exp 000", {rsp_valid, timeout}); end
  endtask

  task automatic test_race();
    @(negedge clk); req[0] = mk(64'h5000, 64'h4, 4'd4, 1'b0, ACC_WRITE); req_valid = 2'b01; ml_ready = 1'b1; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL race_ready: got %b exp 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    repeat (14) @(negedge clk);
    ml_valid = 1'b1; ml_allow = 1'b1; #1;
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL race_early: got %b exp 00", rsp_valid); end
    @(negedge clk); ml_valid = 1'b0; ml_allow = 1'b0; #1;
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL race_rsp: got %b exp 01", rsp_valid); end
    n_checks++; if (rsp_allow !== 1'b1) begin n_fail++; $display("FAIL race_allow: got %b exp 1", rsp_allow); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL race_tmo: got %b exp 0", timeout); end
  endtask

  task automatic test_reset_wait();
    check_req_t exp_req;
    exp_req = mk(64'h6000, 64'h100, 4'd8, 1'b1, ACC_READ);
    @(negedge clk); req[1] = exp_req; req_valid = 2'b10; ml_ready = 1'b1; #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rstw_ready: got %b exp 10", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    n_checks++; if (ml_req !== exp_req) begin n_fail++; $display("FAIL rstw_wait_req: got %h exp %h", ml_req, exp_req); end
    @(negedge clk); rst_ni = 1'b0; #1;
    n_checks++; if ({req_ready, rsp_valid, rsp_allow, ml_en, timeout} !== 7'b0) begin n_fail++; $display("FAIL rstw_outputs: got %b exp 0000000", {req_ready, rsp_valid, rsp_allow, ml_en, timeout}); end
    n_checks++; if (ml_req !== '0) begin n_fail++; $display("FAIL rstw_ml_req: got %h exp 0", ml_req); end
    @(negedge clk); rst_ni = 1'b1;
    @(negedge clk); ml_valid = 1'b1; ml_allow = 1'b1; #1;
    @(negedge clk); ml_valid = 1'b0; ml_allow = 1'b0; #1;
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rstw_late_rsp: got %b exp 00", rsp_valid); end
    @(negedge clk); req_valid = 2'b11; #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstw_ptr_reset: got %b exp 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_valid = 2'b00;
    req       = '0;
    ml_ready  = 1'b0;
    ml_valid  = 1'b0;
    ml_allow  = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_timeout();
    test_race();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
